spi_regfile: RTL and testbench
==============================

# spi_regfile

Parametrised SPI peripheral that terminates a host SPI link and exposes a bank of `NUM_REGS` configuration registers, each `DATA_W` bits, to the rest of the design, e.g. PWM duty and enable registers. It generalises the single-register write-only SPI receiver with:

- configurable address and data widths;
- a per-frame read/write command bit;
- read-back on `cipo`;
- write strobes and a frame-error flag.

All SPI inputs are treated as asynchronous and sampled in the `clk` domain.

## Interface
- `ADDR_W`, default 7: address field width in bits.
- `DATA_W`, default 8: data field and register width in bits.
- `NUM_REGS`, default 5: number of implemented registers, at addresses 0..NUM_REGS-1. Requires NUM_REGS ≤ 2^ADDR_W.
- `SAMPLE_RISING`, default 1:
  - 1: sample `copi` on SCLK rising edge and shift `cipo` on falling edge (mode 0/3).
  - 0: the reverse.
- `clk` in 1: system clock.
- `rst_n` in 1: reset. Asynchronous, active-low; clock `clk`.
- `sclk` in 1: SPI clock, asynchronous.
- `ncs` in 1: SPI chip select, active-low, asynchronous.
- `copi` in 1: SPI controller-out data, asynchronous.
- `cipo` out 1: SPI controller-in data.
- `cipo_oe` out 1: output enable for the `cipo` pad.
- `regs_flat` out NUM_REGS*DATA_W: register contents. Register i occupies bits [i*DATA_W +: DATA_W].
- `wr_strobe` out NUM_REGS: one-`clk` pulse on bit i when register i is updated.
- `frame_err` out 1: one-`clk` pulse when a frame is rejected.

## Operation
- **Synchronisation.** `sclk`, `ncs` and `copi` each pass through a 2-flop synchroniser plus one history flop. Edges are detected on the synchronised value vs the history flop. `ncs` resets to 1; `sclk` and `copi` reset to 0.
- **Frame format.** FRAME_W = 1 + ADDR_W + DATA_W bits, sent MSB first:
  - bit 1: R/W, where 1 = write and 0 = read;
  - next ADDR_W bits: address;
  - last DATA_W bits: data.
- **Bit counting.** A bit counter is held at 0 and the shift register is cleared while synchronised `ncs` = 1. Each sample edge while `ncs` = 0 shifts in `copi` and increments the counter. The counter saturates at FRAME_W+1, so over-length frames never wrap to a valid count.
- **Write commit.** Evaluated on the synchronised `ncs` rising edge. The write commits only if all of the following hold:
  - R/W = 1;
  - count == FRAME_W;
  - addr < NUM_REGS.
  
  On commit, the register is loaded and its `wr_strobe` bit pulses.
- **Write rejection.** A write that fails any of the commit conditions pulses `frame_err`. Registers are unchanged.
- **Frame with count 0.** An `ncs` low/high with no SCLK edges is not an error.
- **Read frames.** When the counter reaches 1+ADDR_W with R/W = 0:
  - if addr < NUM_REGS, the output shift register loads that register;
  - otherwise it loads 0 and an error is latched.
  
  After loading:
  - `cipo` presents the data MSB immediately;
  - `cipo` shifts one bit per shift edge;
  - `cipo_oe` = 1 while `ncs` is low during the data phase.
  
  On the `ncs` rising edge, the latched error pulses `frame_err`, as does a count ≠ FRAME_W.
- **Simultaneous read and write.** A read of a register being written by another master is not possible (single port). A read always returns the value held at address-phase completion.
- **Reset mid-frame.** Asserting `rst_n` mid-frame aborts the frame:
  - all registers return to 0;
  - `cipo` = 0, `cipo_oe` = 0;
  - strobes = 0, `frame_err` = 0.
  
  The first complete frame after reset release is processed normally.

## Timing
- Requires f_sclk ≤ f_clk/8 and `ncs` high time ≥ 4 `clk` cycles.
- Write latency: `regs_flat` and `wr_strobe` update on the 3rd `clk` rising edge after `ncs` rises (2 synchroniser edges + 1 register edge). `wr_strobe` stays high for exactly 1 cycle.
- `cipo` changes 3 `clk` edges after the corresponding SCLK shift edge. The host samples it on the opposite SCLK edge.
- `frame_err` is asserted in the same cycle a commit would occur.

## Configuration
- `SPI_REGFILE_READBACK_EN` defined:
  - the read path, output shift register and `cipo`/`cipo_oe` drivers are built;
  - read frames are processed as above.
- Undefined:
  - `cipo` and `cipo_oe` are tied 0;
  - R/W = 0 frames are treated as invalid and pulse `frame_err`;
  - the write path is unchanged.

## Structure
- Shared package `spi_regfile_pkg`:
  - R/W encoding constants `SPI_CMD_WRITE` = 1'b1 and `SPI_CMD_READ` = 1'b0;
  - frame-width function FRAME_W(ADDR_W, DATA_W).
- Sub-module `spi_sync_edge`: one per SPI input. Contains the 2-flop synchroniser + history flop. Outputs the synchronised level, rising pulse and falling pulse. Has a reset-value parameter.

## Test plan
- **Write, address 2.** Default params; write 0x1_02_A5 (R/W=1, addr 2, data 0xA5) → `regs_flat[23:16]` = 0xA5 and `wr_strobe` = 5'b00100 for 1 cycle, 3 `clk` edges after `ncs` rises; other registers stay 0.
- **Out-of-range address.** Write addr 5, data 0x3C → no register changes, `wr_strobe` = 0, `frame_err` pulses once.
- **Short and long frames.** Frame of 15 bits, then a frame of 17 bits, each targeting addr 0 with data 0xFF → register 0 stays 0x00; two `frame_err` pulses.
- **Read-back (macro defined).** After writing 0x5A to addr 4, a read of addr 4 → host captures 0x5A on `cipo`, with `cipo_oe` = 1 only during the 8 data bits. Read of addr 6 → 0x00 and a `frame_err` pulse.
- **Reset mid-frame.** Assert `rst_n` low after 10 bits of a write to addr 1 → all outputs 0. The next full write of 0x77 to addr 1 lands normally.
- **Non-default parameters.** ADDR_W=4, DATA_W=16, NUM_REGS=16, SAMPLE_RISING=0; write 0xBEEF to addr 15 → bits [255:240] = 0xBEEF.

Source files
------------

// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI register file: command encodings and the
// frame-length helper used by the top level and the testbench.
package spi_regfile_pkg;

  localparam logic SPI_CMD_WRITE = 1'b1;
  localparam logic SPI_CMD_READ  = 1'b0;

  // One R/W bit, then the address field, then the data field.
  function automatic int FRAME_W(input int addrW, input int dataW);
    return 1 + addrW + dataW;
  endfunction

endpackage

// File: rtl/spi_regfile_if.sv
// SPI pin bundle between a host (master) and the register file (slave).
interface spi_regfile_if;

  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (
    output sclk,
    output ncs,
    output copi,
    input  cipo,
    input  cipo_oe
  );

  modport slave (
    input  sclk,
    input  ncs,
    input  copi,
    output cipo,
    output cipo_oe
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Brings one asynchronous SPI pin into the clk domain through two flops and
// keeps a third history flop so edges can be seen as single-cycle pulses.
// RESET_VAL sets the idle level the chain powers up with.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // Two-stage synchroniser followed by a history stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      hist_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~hist_q;
  assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_regfile.sv
// SPI slave exposing NUM_REGS registers of DATA_W bits. Frames are
// R/W bit, address, data, MSB first. Writes commit when chip select rises.
// Optional read-back path is enabled by defining SPI_REGFILE_READBACK_EN;
// without it cipo/cipo_oe are tied low and read frames are rejected.
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int ADDR_W        = 7,
  parameter int DATA_W        = 8,
  parameter int NUM_REGS      = 5,
  parameter bit SAMPLE_RISING = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_regfile_if.slave                 spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int FRAME_BITS = FRAME_W(ADDR_W, DATA_W);
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_BITS + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic sclkLevel, sclkRise, sclkFall;
  logic ncsLevel,  ncsRise,  ncsFall;
  logic copiLevel, copiRise, copiFall;
  logic unused_sync;

  spi_sync_edge #(.RESET_VAL(1'b0)) uSclkSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi.sclk),
    .level_o (sclkLevel),
    .rise_o  (sclkRise),
    .fall_o  (sclkFall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) uNcsSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi.ncs),
    .level_o (ncsLevel),
    .rise_o  (ncsRise),
    .fall_o  (ncsFall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) uCopiSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi.copi),
    .level_o (copiLevel),
    .rise_o  (copiRise),
    .fall_o  (copiFall)
  );

  assign unused_sync = ^{sclkLevel, ncsFall, copiRise, copiFall};

  logic sampleEdge;
  assign sampleEdge = SAMPLE_RISING ? sclkRise : sclkFall;

  logic [CNT_W-1:0]      count_q, count_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;

  // Next-state for the bit counter and input shifter; both idle at 0 while deselected
  always_comb begin
    count_d = count_q;
    shift_d = shift_q;
    if (ncsLevel) begin
      count_d = '0;
      shift_d = '0;
    end else if (sampleEdge) begin
      shift_d = {shift_q[FRAME_BITS-2:0], copiLevel};
      if (count_q != CNT_SAT) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Frame bit counter and input shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      shift_q <= '0;
    end else begin
      count_q <= count_d;
      shift_q <= shift_d;
    end
  end

  logic              rwBit;
  logic [ADDR_W-1:0] frameAddr;
  logic [DATA_W-1:0] frameData;
  logic              frameAddrOk;
  logic              writeOk;
  logic              readOk;
  logic              frameBad;

  assign rwBit       = shift_q[FRAME_BITS-1];
  assign frameAddr   = shift_q[DATA_W +: ADDR_W];
  assign frameData   = shift_q[DATA_W-1:0];
  assign frameAddrOk = {1'b0, frameAddr} < NUM_REGS_W;

  // A frame is judged once, when the synchronised chip select goes high
  assign writeOk  = ncsRise && (rwBit == SPI_CMD_WRITE) && (count_q == CNT_FULL) && frameAddrOk;
  assign frameBad = ncsRise && (count_q != '0) && !writeOk && !readOk;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wrStrobe_d, wrStrobe_q;
  logic                frameErr_q;

  // One-hot select of the register addressed by a committing write
  always_comb begin
    wrStrobe_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wrStrobe_d[i] = writeOk && (frameAddr == ADDR_W'(i));
    end
  end

  // Register bank plus the one-cycle strobe and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wrStrobe_q <= '0;
      frameErr_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wrStrobe_d[i]) begin
          regs_q[i] <= frameData;
        end
      end
      wrStrobe_q <= wrStrobe_d;
      frameErr_q <= frameBad;
    end
  end

  // Flatten the bank onto the output bus, register i at [i*DATA_W +: DATA_W]
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  assign wr_strobe = wrStrobe_q;
  assign frame_err = frameErr_q;

`ifdef SPI_REGFILE_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(1 + ADDR_W);

  logic              shiftEdge;
  logic [ADDR_W-1:0] rdAddr;
  logic              rdAddrOk;
  logic [DATA_W-1:0] rdData;
  logic              rdLoad;
  logic              shiftEnable;
  logic [DATA_W-1:0] outShift_q;
  logic              cipoOe_q;
  logic              rdErr_q;

  assign shiftEdge = SAMPLE_RISING ? sclkFall : sclkRise;

  // The address is complete in shift_d on the sample edge that ends the address phase
  assign rdAddr   = shift_d[ADDR_W-1:0];
  assign rdAddrOk = {1'b0, rdAddr} < NUM_REGS_W;
  assign rdLoad   = sampleEdge && !ncsLevel && (count_d == CNT_ADDR) &&
                    (shift_d[ADDR_W] == SPI_CMD_READ);

  // The shift edge right after loading must not disturb the MSB the host has not sampled yet
  assign shiftEnable = shiftEdge && cipoOe_q && (count_q > CNT_ADDR);

  // Read mux; out-of-range addresses match nothing and return 0
  always_comb begin
    rdData = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rdAddr == ADDR_W'(i)) begin
        rdData = regs_q[i];
      end
    end
  end

  // Output shifter, pad enable and the latched bad-address flag for read frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outShift_q <= '0;
      cipoOe_q   <= 1'b0;
      rdErr_q    <= 1'b0;
    end else if (ncsLevel) begin
      outShift_q <= '0;
      cipoOe_q   <= 1'b0;
      rdErr_q    <= 1'b0;
    end else if (rdLoad) begin
      outShift_q <= rdData;
      cipoOe_q   <= 1'b1;
      rdErr_q    <= ~rdAddrOk;
    end else if (shiftEnable) begin
      outShift_q <= {outShift_q[DATA_W-2:0], 1'b0};
    end
  end

  assign readOk      = (rwBit == SPI_CMD_READ) && (count_q == CNT_FULL) && !rdErr_q;
  assign spi.cipo    = outShift_q[DATA_W-1];
  assign spi.cipo_oe = cipoOe_q;
`else
  assign readOk      = 1'b0;
  assign spi.cipo    = 1'b0;
  assign spi.cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Testbench for spi_regfile: a default-parameter instance driven from a
// table of frames, plus a wide instance (ADDR_W=4, DATA_W=16, NUM_REGS=16,
// SAMPLE_RISING=0). Read-back expectations follow SPI_REGFILE_READBACK_EN.
module tb_spi_regfile;

  localparam int HALF = 8;
  localparam int NVEC = 12;

`ifdef SPI_REGFILE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  spi_regfile_if spiA();
  spi_regfile_if spiB();

  logic [39:0]  regsA;
  logic [4:0]   strbA;
  logic         errA;
  logic [255:0] regsB;
  logic [15:0]  strbB;
  logic         errB;

  spi_regfile dutA (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spiA.slave),
    .regs_flat (regsA),
    .wr_strobe (strbA),
    .frame_err (errA)
  );

  spi_regfile #(
    .ADDR_W        (4),
    .DATA_W        (16),
    .NUM_REGS      (16),
    .SAMPLE_RISING (1'b0)
  ) dutB (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spiB.slave),
    .regs_flat (regsB),
    .wr_strobe (strbB),
    .frame_err (errB)
  );

  typedef struct {
    int          nBits;
    logic [31:0] bits;
    logic [39:0] expRegs;
    logic [4:0]  expStrobe;
    int          expErr;
    logic [7:0]  expRead;
    int          expOe;
  } vec_t;

  vec_t vecs [NVEC];

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] captBits;
  int          oeSamples;
  logic [15:0] strbOr;
  int          strbCycles;
  int          strbFirst;
  int          errCycles;
  int          errFirst;
  logic        oeAfter;

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setNcs(input int dev, input logic v);
    if (dev == 0) spiA.ncs = v;
    else          spiB.ncs = v;
  endtask

  task automatic setSclk(input int dev, input logic v);
    if (dev == 0) spiA.sclk = v;
    else          spiB.sclk = v;
  endtask

  task automatic setCopi(input int dev, input logic v);
    if (dev == 0) spiA.copi = v;
    else          spiB.copi = v;
  endtask

  function automatic logic cipoOf(input int dev);
    return (dev == 0) ? spiA.cipo : spiB.cipo;
  endfunction

  function automatic logic oeOf(input int dev);
    return (dev == 0) ? spiA.cipo_oe : spiB.cipo_oe;
  endfunction

  function automatic logic [15:0] strobeOf(input int dev);
    return (dev == 0) ? {11'b0, strbA} : strbB;
  endfunction

  function automatic logic errOf(input int dev);
    return (dev == 0) ? errA : errB;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One SCLK period: drive copi, sample edge (host captures cipo), then shift edge
  task automatic clockBit(input int dev, input logic b);
    logic idle;
    idle = (dev == 0) ? 1'b0 : 1'b1;
    setCopi(dev, b);
    waitClk(HALF);
    setSclk(dev, ~idle);
    captBits = {captBits[30:0], cipoOf(dev)};
    if (oeOf(dev) === 1'b1) oeSamples++;
    waitClk(HALF);
    setSclk(dev, idle);
  endtask

  // Full frame of nBits (MSB first), then watch strobe/err for 8 cycles after ncs rises
  task automatic applyStimulus(input int dev, input int nBits, input logic [31:0] bits);
    logic [15:0] s;
    captBits   = '0;
    oeSamples  = 0;
    strbOr     = '0;
    strbCycles = 0;
    strbFirst  = 0;
    errCycles  = 0;
    errFirst   = 0;
    setNcs(dev, 1'b0);
    waitClk(HALF);
    for (int b = nBits - 1; b >= 0; b--) begin
      clockBit(dev, bits[b]);
    end
    waitClk(HALF);
    setNcs(dev, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      waitClk(1);
      s = strobeOf(dev);
      if (s != '0) begin
        if (strbFirst == 0) strbFirst = k;
        strbCycles++;
        strbOr = strbOr | s;
      end
      if (errOf(dev) === 1'b1) begin
        if (errFirst == 0) errFirst = k;
        errCycles++;
      end
    end
    oeAfter = oeOf(dev);
    waitClk(4);
  endtask

  initial begin
    int expPulse;
    logic [31:0] partial;

    rst_n     = 1'b0;
    spiA.sclk = 1'b0;
    spiA.ncs  = 1'b1;
    spiA.copi = 1'b0;
    spiB.sclk = 1'b1;
    spiB.ncs  = 1'b1;
    spiB.copi = 1'b0;

    vecs[0]  = '{16, 32'h82A5,  40'h00_00_A5_00_00, 5'b00100, 0, 8'h00, 0};
    vecs[1]  = '{16, 32'h853C,  40'h00_00_A5_00_00, 5'b00000, 1, 8'h00, 0};
    vecs[2]  = '{15, 32'h407F,  40'h00_00_A5_00_00, 5'b00000, 1, 8'h00, 0};
    vecs[3]  = '{17, 32'h101FF, 40'h00_00_A5_00_00, 5'b00000, 1, 8'h00, 0};
    vecs[4]  = '{16, 32'h845A,  40'h5A_00_A5_00_00, 5'b10000, 0, 8'h00, 0};
    vecs[5]  = '{16, 32'h0400,  40'h5A_00_A5_00_00, 5'b00000, RB ? 0 : 1, RB ? 8'h5A : 8'h00, RB ? 8 : 0};
    vecs[6]  = '{16, 32'h0600,  40'h5A_00_A5_00_00, 5'b00000, 1, 8'h00, RB ? 8 : 0};
    vecs[7]  = '{0,  32'h0000,  40'h5A_00_A5_00_00, 5'b00000, 0, 8'h00, 0};
    vecs[8]  = '{16, 32'h8011,  40'h5A_00_A5_00_11, 5'b00001, 0, 8'h00, 0};
    vecs[9]  = '{16, 32'hFFFF,  40'h5A_00_A5_00_11, 5'b00000, 1, 8'h00, 0};
    vecs[10] = '{16, 32'h83C3,  40'h5A_C3_A5_00_11, 5'b01000, 0, 8'h00, 0};
    vecs[11] = '{16, 32'h0300,  40'h5A_C3_A5_00_11, 5'b00000, RB ? 0 : 1, RB ? 8'hC3 : 8'h00, RB ? 8 : 0};

    waitClk(4);
    checkOutput("reset regsA", 256'(regsA), 256'(0));
    checkOutput("reset strobeA", 256'(strbA), 256'(0));
    checkOutput("reset errA", 256'(errA), 256'(0));
    checkOutput("reset cipoA", 256'(spiA.cipo), 256'(0));
    checkOutput("reset oeA", 256'(spiA.cipo_oe), 256'(0));
    checkOutput("reset regsB", regsB, 256'(0));
    rst_n = 1'b1;
    waitClk(8);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(0, vecs[i].nBits, vecs[i].bits);
      expPulse = (vecs[i].expStrobe != '0) ? 1 : 0;
      checkOutput($sformatf("vec%0d regs", i), 256'(regsA), 256'(vecs[i].expRegs));
      checkOutput($sformatf("vec%0d strobe", i), 256'(strbOr), 256'(vecs[i].expStrobe));
      checkOutput($sformatf("vec%0d strobe cycles", i), 256'(strbCycles), 256'(expPulse));
      checkOutput($sformatf("vec%0d strobe latency", i), 256'(strbFirst), 256'(expPulse * 3));
      checkOutput($sformatf("vec%0d err cycles", i), 256'(errCycles), 256'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d err latency", i), 256'(errFirst), 256'(vecs[i].expErr * 3));
      checkOutput($sformatf("vec%0d read data", i), 256'(captBits[7:0]), 256'(vecs[i].expRead));
      checkOutput($sformatf("vec%0d oe samples", i), 256'(oeSamples), 256'(vecs[i].expOe));
      checkOutput($sformatf("vec%0d oe idle", i), 256'(oeAfter), 256'(0));
    end

    // Reset in the middle of a write to address 1
    $display("[TB] reset mid-frame sequence");
    partial    = 32'h8177;
    captBits   = '0;
    oeSamples  = 0;
    spiA.ncs   = 1'b0;
    waitClk(HALF);
    for (int b = 15; b >= 6; b--) begin
      clockBit(0, partial[b]);
    end
    rst_n = 1'b0;
    waitClk(2);
    checkOutput("midreset regsA", 256'(regsA), 256'(0));
    checkOutput("midreset strobeA", 256'(strbA), 256'(0));
    checkOutput("midreset errA", 256'(errA), 256'(0));
    checkOutput("midreset cipoA", 256'(spiA.cipo), 256'(0));
    checkOutput("midreset oeA", 256'(spiA.cipo_oe), 256'(0));
    spiA.ncs  = 1'b1;
    spiA.copi = 1'b0;
    waitClk(4);
    rst_n = 1'b1;
    waitClk(8);
    applyStimulus(0, 16, 32'h8177);
    checkOutput("postreset regsA", 256'(regsA), 256'(40'h00_00_00_77_00));
    checkOutput("postreset strobe", 256'(strbOr), 256'(5'b00010));
    checkOutput("postreset strobe latency", 256'(strbFirst), 256'(3));
    checkOutput("postreset err cycles", 256'(errCycles), 256'(0));

    // Wide instance, falling-edge sampling: 0xBEEF to address 15
    $display("[TB] wide instance write");
    applyStimulus(1, 21, 32'h1F_BEEF);
    checkOutput("wide reg15", 256'(regsB[255:240]), 256'(16'hBEEF));
    checkOutput("wide others", 256'(regsB[239:0]), 256'(0));
    checkOutput("wide strobe", 256'(strbOr), 256'(16'h8000));
    checkOutput("wide strobe cycles", 256'(strbCycles), 256'(1));
    checkOutput("wide strobe latency", 256'(strbFirst), 256'(3));
    checkOutput("wide err cycles", 256'(errCycles), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
